// File: rtl/dev_req_sequencer.sv
// Request front-end for master_port: queues local read/write requests, issues them one at a
// time over the dvalid/dready interface and returns one response per request, with a timeout.
module dev_req_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_mode,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_mode,
    output logic                  d_valid,
    input  logic                  d_ready,
    input  logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  busy,
    output logic [7:0]            txn_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  mode;
    } req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE,
        RESP
    } state_t;

    req_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nx;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             load;
    logic             done;
    logic             abort;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign pop       = done || abort;
    assign busy      = !empty || (state != IDLE);
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: req_addr, wdata: req_wdata, mode: req_mode};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && d_ready) begin
                    state_nx = ISSUE;
                    load     = 1'b1;
                end
            end
            ISSUE: state_nx = WAIT_ACC;
            WAIT_ACC: begin
                if (tmo_hit) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end else if (!d_ready) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // A completion arriving on the last allowed cycle still counts as a success.
                if (d_ready) begin
                    done     = 1'b1;
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    abort    = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid   <= 1'b0;
            d_addr    <= '0;
            d_wdata   <= '0;
            d_mode    <= 1'b0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_mode  <= 1'b0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            d_valid <= load;
            if (load) begin
                d_addr  <= fifo_mem[rd_ptr].addr;
                d_wdata <= fifo_mem[rd_ptr].wdata;
                d_mode  <= fifo_mem[rd_ptr].mode;
            end

            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state inside {WAIT_ACC, WAIT_DONE}) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (done) begin
                rsp_valid <= 1'b1;
                rsp_mode  <= d_mode;
                rsp_err   <= 1'b0;
                rsp_rdata <= d_mode ? '0 : d_rdata;
                txn_count <= txn_count + 1'b1;
            end else if (abort) begin
                rsp_valid <= 1'b1;
                rsp_mode  <= d_mode;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
